// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache with line refill over a valid/ready memory port.
// Lines refill from word 0 upward, with requests pipelined ahead of in-order responses.
module instruction_cache_dm #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int LINES   = 16,
  parameter int WORDS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_pc,
  output logic               resp_valid,
  output logic [INSTR_W-1:0] resp_instr,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [INSTR_W-1:0] mem_resp_data,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = ADDR_W - 2 - OB - IB;

  localparam logic [OB:0] WLAST = (OB+1)'(WORDS - 1);
  localparam logic [OB:0] WCNT  = (OB+1)'(WORDS);
  localparam logic [OB:0] WONE  = (OB+1)'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [OB:0]        req_i_q, req_i_d;
  logic [OB:0]        rsp_i_q, rsp_i_d;
  logic               fpend_q, fpend_d;
  logic [INSTR_W-1:0] resp_q;
  logic [31:0]        hit_q, hit_d;
  logic [31:0]        miss_q, miss_d;

  logic [TW-1:0]      tag_mem  [LINES];
  logic [INSTR_W-1:0] data_mem [LINES*WORDS];

  logic [IB-1:0]      idx;
  logic [OB-1:0]      word;
  logic [TW-1:0]      tag;
  logic               hit;
  logic               last;
  logic [INSTR_W-1:0] rd_word;
  logic               unused_pc_lsb;

  assign idx  = pc_q[2+OB +: IB];
  assign word = pc_q[2 +: OB];
  assign tag  = pc_q[ADDR_W-1 -: TW];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
  assign rd_word = data_mem[{idx, word}];
  assign unused_pc_lsb = ^pc_q[1:0];

  assign last = (state_q == S_REFILL) && mem_resp_valid
             && (rsp_i_q == WLAST);

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REFILL) && (req_i_q != WCNT);
  assign mem_req_addr  = {tag, idx, req_i_q[OB-1:0], 2'b00};
  assign resp_valid    = ((state_q == S_LOOKUP) && hit)
                      || (state_q == S_RESP);
  assign resp_instr    = resp_valid ? rd_word : resp_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    req_i_d = req_i_q;
    rsp_i_d = rsp_i_q;
    fpend_d = fpend_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pc_d    = req_pc;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_d   = hit_q + 32'd1;
          state_d = S_IDLE;
        end else begin
          miss_d  = miss_q + 32'd1;
          req_i_d = '0;
          rsp_i_d = '0;
          fpend_d = 1'b0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_req_valid && mem_req_ready) req_i_d = req_i_q + WONE;
        if (mem_resp_valid) rsp_i_d = rsp_i_q + WONE;
        if (flush) fpend_d = 1'b1;
        // A flush seen at any point of the refill keeps the new line invalid
        if (last) begin
          if (fpend_q || flush) valid_d = '0;
          else valid_d[idx] = 1'b1;
          fpend_d = 1'b0;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush && (state_q != S_REFILL)) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      valid_q <= '0;
      req_i_q <= '0;
      rsp_i_q <= '0;
      fpend_q <= 1'b0;
      resp_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      req_i_q <= req_i_d;
      rsp_i_q <= rsp_i_d;
      fpend_q <= fpend_d;
      resp_q  <= resp_instr;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_REFILL) && mem_resp_valid)
      data_mem[{idx, rsp_i_q[OB-1:0]}] <= mem_resp_data;
    if (!rst && last)
      tag_mem[idx] <= tag;
  end

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Randomized bench for instruction_cache_dm against a line-level cache model
// and an in-order memory model with random ready/response timing.
module tb_instruction_cache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  instruction_cache_dm dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_instr(resp_instr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
  endfunction

  logic [63:0] mq[$];
  logic [63:0] hs_q[$];
  int          stall_left = 0;
  logic        prev_pend = 1'b0;
  logic [63:0] prev_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("hold_v", {63'd0, mem_req_valid}, 64'd1);
        chk("hold_a", mem_req_addr, prev_addr);
      end
      prev_pend = mem_req_valid && !mem_req_ready;
      prev_addr = mem_req_addr;
      if (mem_req_valid && mem_req_ready) begin
        mq.push_back(mem_req_addr);
        hs_q.push_back(mem_req_addr);
      end
      if (mem_resp_valid && mq.size() > 0) void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
    end else begin
      if (stall_left > 0 && mem_req_valid) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = ($urandom_range(3) != 0);
      end
      mem_resp_valid = (mq.size() > 0) && ($urandom_range(4) != 0);
      mem_resp_data  = mem_resp_valid ? mw(mq[0]) : 32'hDEADBEEF;
    end
  end

  logic        mv[16];
  logic [63:0] ml[16];
  int          mhit = 0;
  int          mmiss = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // fk: cycle after accept in which flush is driven, or -1 for none
  task automatic fetch(input logic [63:0] pc, input int fk);
    int          idx;
    int          cyc;
    logic        hit;
    logic        got;
    logic        fl;
    logic [63:0] line;
    logic [31:0] exp;
    line = pc >> 4;
    idx  = int'(line[3:0]);
    hit  = mv[idx] && (ml[idx] == line);
    exp  = mw({pc[63:2], 2'b00});
    cyc  = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_pc    = pc;
    hs_q.delete();
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    fl  = 1'b0;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (resp_valid) got = 1'b1;
      else if (cyc == fk) begin
        flush = 1'b1;
        fl    = 1'b1;
      end
    end
    flush = 1'b0;
    chk("resp_seen", {63'd0, got}, 64'd1);
    chk("instr", {32'd0, resp_instr}, {32'd0, exp});
    if (hit) begin
      chk("hit_lat", 64'(cyc), 64'd1);
      chk("hit_nomem", 64'(hs_q.size()), 64'd0);
      mhit++;
    end else begin
      chk("refill_n", 64'(hs_q.size()), 64'd4);
      for (int i = 0; i < hs_q.size() && i < 4; i++)
        chk("refill_a", hs_q[i], (line << 4) + 64'(4 * i));
      mmiss++;
    end
    if (fl) model_clear();
    if (!hit && !(fl && fk >= 2)) begin
      mv[idx] = 1'b1;
      ml[idx] = line;
    end
    @(negedge clk);
    chk("instr_hold", {32'd0, resp_instr}, {32'd0, exp});
    chk("hits", {32'd0, hit_count}, 64'(mhit));
    chk("misses", {32'd0, miss_count}, 64'(mmiss));
  endtask

  initial begin
    int          m0;
    int          tg;
    int          fk;
    logic [63:0] pc;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rv", {63'd0, resp_valid}, 64'd0);
    chk("rst_instr", {32'd0, resp_instr}, 64'd0);
    chk("rst_mv", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_ma", mem_req_addr, 64'd0);
    chk("rst_hits", {32'd0, hit_count}, 64'd0);
    chk("rst_miss", {32'd0, miss_count}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    fetch(64'h40, -1);
    fetch(64'h4C, -1);
    chk("t2_hits", {32'd0, hit_count}, 64'd1);

    m0 = mmiss;
    fetch(64'h140, -1);
    fetch(64'h40, -1);
    chk("t3_conflict", {32'd0, miss_count}, 64'(m0 + 2));

    stall_left = 5;
    fetch(64'h3008, -1);
    chk("t4_stalled", 64'(stall_left), 64'd0);

    fetch(64'h80, 3);
    m0 = mmiss;
    fetch(64'h80, -1);
    chk("t5_remiss", {32'd0, miss_count}, 64'(m0 + 1));

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    m0 = mmiss;
    fetch(64'h4C, -1);
    chk("idle_flush", {32'd0, miss_count}, 64'(m0 + 1));

    for (int n = 0; n < 250; n++) begin
      tg = $urandom_range(3);
      pc = (tg == 3) ? 64'hF000_0000_0000_0000 : 64'(tg) << 8;
      pc = pc | (64'($urandom_range(15)) << 4)
              | (64'($urandom_range(3)) << 2)
              | 64'($urandom_range(3));
      fk = ($urandom_range(9) == 0) ? $urandom_range(1, 4) : -1;
      fetch(pc, fk);
      if ($urandom_range(29) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end
    end

    req_valid = 1'b1;
    req_pc    = 64'h200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy", {63'd0, req_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready", {63'd0, req_ready}, 64'd1);
    chk("t6_mv", {63'd0, mem_req_valid}, 64'd0);
    chk("t6_hits", {32'd0, hit_count}, 64'd0);
    chk("t6_miss", {32'd0, miss_count}, 64'd0);
    chk("t6_instr", {32'd0, resp_instr}, 64'd0);
    rst = 1'b0;
    model_clear();
    mhit  = 0;
    mmiss = 0;
    @(negedge clk);
    fetch(64'h40, -1);
    chk("t6_refetch", {32'd0, miss_count}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
